sr_cmd_sequencer: RTL
=====================

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 4, giving the number of WAIT cycles allowed for q_fb to reach the target (legal range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of op_cnt.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 Port set_req, input, 1, level request to drive the downstream SR flip-flop to q=1.
REQ-006 Port clr_req, input, 1, level request to drive the downstream SR flip-flop to q=0.
REQ-007 Port q_fb, input, 1, q output of the downstream SR flip-flop, fed back for confirmation.
REQ-008 Port s, output, 1, set drive to the downstream SR flip-flop.
REQ-009 Port r, output, 1, reset drive to the downstream SR flip-flop.
REQ-010 Port busy, output, 1, high whenever state is not IDLE.
REQ-011 Port done, output, 1, one-cycle pulse on successful completion.
REQ-012 Port err, output, 1, sticky timeout flag.
REQ-013 Port conflict, output, 1, one-cycle pulse when set_req and clr_req are both high in IDLE.
REQ-014 Port op_cnt, output, CNT_W, count of completed driven operations.

Function
REQ-015 The block SHALL implement the states IDLE, DRIVE, WAIT, DONE and ERR, with all outputs decoded from registered state or registered flags.
REQ-016 In IDLE, set_req=1 and clr_req=1 together SHALL leave the state at IDLE and pulse conflict for the following cycle.
REQ-017 In IDLE, a single request whose target already equals q_fb SHALL go to DONE without entering DRIVE (no-op), and op_cnt SHALL NOT increment.
REQ-018 Otherwise, in IDLE, a single request SHALL latch target (set=1, clr=0), clear err, and go to DRIVE.
REQ-019 DRIVE SHALL last exactly one cycle with s=target and r=~target, then go to WAIT with the timer at 0.
REQ-020 In WAIT, s=0 and r=0; if q_fb==target the state SHALL go to DONE, otherwise the timer SHALL increment.
REQ-021 In WAIT, when the timer reaches TIMEOUT-1 without a match, the state SHALL go to ERR.
REQ-022 DONE SHALL assert done for exactly one cycle, increment op_cnt for driven operations, and return to IDLE.
REQ-023 ERR SHALL set err, which stays high until the next accepted request, then return to IDLE after one cycle; done SHALL NOT pulse in this case.
REQ-024 op_cnt SHALL wrap from 2^CNT_W-1 to 0 without saturation or a flag.
REQ-025 Requests seen while busy=1 SHALL be ignored and not queued; a request still held high on return to IDLE SHALL be accepted.
REQ-026 s and r SHALL never both be 1 in any cycle, including during and immediately after reset.
REQ-027 Latency: for a request sampled at edge N with an ideal SR flip-flop downstream, s (or r) is high in cycle N..N+1, and done is high in cycle N+3..N+4.

Reset
REQ-028 While rst=0, the block SHALL immediately (asynchronously) set state=IDLE, s=0, r=0, busy=0, done=0, err=0, conflict=0, op_cnt=0 and timer=0.
REQ-029 Reset asserted mid-operation (DRIVE/WAIT/DONE/ERR) SHALL abort the operation with no done or err pulse; the first request after rst returns to 1 SHALL be handled as a fresh request from IDLE.

Verification
REQ-030 Reset, then set_req=1 for 1 cycle with downstream q=0 -> s=1 for 1 cycle, done pulses at request edge +3, op_cnt=1, r stays 0.
REQ-031 With q=1, pulse clr_req -> r=1 for 1 cycle, q_fb falls, done pulses, op_cnt increments; then pulse clr_req again -> done pulses, no r drive, op_cnt unchanged.
REQ-032 set_req=clr_req=1 in IDLE -> conflict pulses 1 cycle, s=r=0, busy=0, op_cnt unchanged.
REQ-033 q_fb held at 0, pulse set_req with TIMEOUT=4 -> 4 WAIT cycles, err=1 sticky, no done; next set_req with a responsive q_fb clears err and completes.
REQ-034 Assert rst=0 during WAIT -> all outputs reset immediately with no done; with CNT_W=2, after 4 driven ops op_cnt=0 (wrap); check s&r==0 on every cycle.

Source files
------------

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for a downstream SR flip-flop: drives s or r for one cycle,
// then waits for the fed-back q to confirm the target, with timeout and op count.
module sr_cmd_sequencer #(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_req,
  input  logic             clr_req,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             conflict,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, DONE, ERR} state_e;

  localparam logic [3:0] TMR_LAST = 4'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             target_q, target_d;
  logic             driven_q, driven_d;
  logic             err_q, err_d;
  logic             conflict_q, conflict_d;
  logic             q_fb_q;
  logic [3:0]       timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= 1'b0;
      driven_q   <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
      q_fb_q     <= 1'b0;
      timer_q    <= 4'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      driven_q   <= driven_d;
      err_q      <= err_d;
      conflict_q <= conflict_d;
      q_fb_q     <= q_fb;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
    end
  end

  // Feedback is registered once, so confirmation lands one cycle after the
  // downstream flop has captured the drive.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    driven_d   = driven_q;
    err_d      = err_q;
    conflict_d = 1'b0;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (set_req && clr_req) begin
          conflict_d = 1'b1;
        end else if (set_req || clr_req) begin
          target_d = set_req;
          err_d    = 1'b0;
          if (set_req == q_fb_q) begin
            driven_d = 1'b0;
            state_d  = DONE;
          end else begin
            driven_d = 1'b1;
            state_d  = DRIVE;
          end
        end
      end
      DRIVE: begin
        timer_d = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (q_fb_q == target_q) begin
          state_d = DONE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      DONE: begin
        if (driven_q) cnt_d = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s        = (state_q == DRIVE) &&  target_q;
  assign r        = (state_q == DRIVE) && !target_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign conflict = conflict_q;
  assign op_cnt   = cnt_q;

endmodule
